// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU-drive / response bundle for alu_issue_ctrl.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the response side.
//
// Ports (signals):
//   request  : in_valid, in_ready, in_a, in_b, alu_op, funct3, funct7_5
//   ALU drive: alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_operation
//   ALU ret  : alu_result, alu_carry_out, alu_zf
//   response : out_valid, out_ready, out_result, out_carry, out_zero, out_illegal, out_taken
// slave is the controller's view; master is the requester/ALU environment's view.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_a_invert;
    logic             alu_b_invert;
    logic             alu_carry_in;
    logic [1:0]       alu_operation;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry_out;
    logic             alu_zf;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic             out_taken;

    modport slave (
        input  in_valid, in_a, in_b, alu_op, funct3, funct7_5,
        input  alu_result, alu_carry_out, alu_zf,
        input  out_ready,
        output in_ready,
        output alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_operation,
        output out_valid, out_result, out_carry, out_zero, out_illegal, out_taken
    );

    modport master (
        output in_valid, in_a, in_b, alu_op, funct3, funct7_5,
        output alu_result, alu_carry_out, alu_zf,
        output out_ready,
        input  in_ready,
        input  alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_operation,
        input  out_valid, out_result, out_carry, out_zero, out_illegal, out_taken
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded op to an external combinational ALU and returns a registered response.
// Latency: accept edge -> EXEC; next edge captures ALU outputs and raises out_valid (3 cycles min per op).
// Backpressure: in_ready only in IDLE; response held stable in DONE until out_ready.
//
// Ports: clk, rst_n (async active-low), bus (alu_issue_ctrl_if.slave: request, ALU drive/return, response).
// Optional feature: define ALU_BRANCH_EVAL_EN to evaluate BEQ/BNE into out_taken for alu_op 01;
// without it alu_op 01 is a plain SUB and out_taken stays 0.
module alu_issue_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t r_state, w_state_nxt;
    logic   w_in_ready, w_out_valid, w_accept, w_capture, w_release;

    // decoded controls for the request currently on the input side
    logic       w_legal, w_b_inv, w_cin;
    logic [1:0] w_op;

    logic [WIDTH-1:0] r_alu_a, r_alu_b;
    logic             r_alu_b_inv, r_alu_cin, r_illegal;
    logic [1:0]       r_alu_op;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_carry, r_out_zero, r_out_illegal;

`ifdef ALU_BRANCH_EVAL_EN
    logic w_branch, w_br_ne;
    logic r_branch, r_br_ne, r_out_taken;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- decode ----------------
    // ALU operation codes: 00 AND, 01 OR, 10 ADD. SUB is ADD with inverted B and carry-in 1.
    always_comb begin
        w_legal = 1'b0;
        w_b_inv = 1'b0;
        w_cin   = 1'b0;
        w_op    = 2'b00;
`ifdef ALU_BRANCH_EVAL_EN
        w_branch = 1'b0;
        w_br_ne  = 1'b0;
`endif
        case (bus.alu_op)
            2'b00: begin
                w_legal = 1'b1;
                w_op    = 2'b10;
            end
            2'b01: begin
`ifdef ALU_BRANCH_EVAL_EN
                // only BEQ (000) and BNE (001) are branch compares we can resolve
                if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
                    w_legal  = 1'b1;
                    w_b_inv  = 1'b1;
                    w_cin    = 1'b1;
                    w_op     = 2'b10;
                    w_branch = 1'b1;
                    w_br_ne  = bus.funct3[0];
                end
`else
                w_legal = 1'b1;
                w_b_inv = 1'b1;
                w_cin   = 1'b1;
                w_op    = 2'b10;
`endif
            end
            2'b10: begin
                case ({bus.funct7_5, bus.funct3})
                    4'b0_000: begin w_legal = 1'b1; w_op = 2'b10; end
                    4'b1_000: begin w_legal = 1'b1; w_op = 2'b10; w_b_inv = 1'b1; w_cin = 1'b1; end
                    4'b0_111: begin w_legal = 1'b1; w_op = 2'b00; end
                    4'b0_110: begin w_legal = 1'b1; w_op = 2'b01; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_b_inv   <= 1'b0;
            r_alu_cin     <= 1'b0;
            r_alu_op      <= 2'b00;
            r_illegal     <= 1'b0;
            r_out_result  <= '0;
            r_out_carry   <= 1'b0;
            r_out_zero    <= 1'b0;
            r_out_illegal <= 1'b0;
`ifdef ALU_BRANCH_EVAL_EN
            r_branch      <= 1'b0;
            r_br_ne       <= 1'b0;
            r_out_taken   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                // an illegal op drives the ALU with all zeros
                r_alu_a     <= w_legal ? bus.in_a : '0;
                r_alu_b     <= w_legal ? bus.in_b : '0;
                r_alu_b_inv <= w_b_inv;
                r_alu_cin   <= w_cin;
                r_alu_op    <= w_op;
                r_illegal   <= !w_legal;
`ifdef ALU_BRANCH_EVAL_EN
                r_branch    <= w_branch;
                r_br_ne     <= w_br_ne;
`endif
            end else if (w_release) begin
                r_alu_a     <= '0;
                r_alu_b     <= '0;
                r_alu_b_inv <= 1'b0;
                r_alu_cin   <= 1'b0;
                r_alu_op    <= 2'b00;
            end
            if (w_capture) begin
                // the all-zero drive makes the ALU report zf=1, so the response is forced, not copied
                r_out_result  <= r_illegal ? '0 : bus.alu_result;
                r_out_carry   <= !r_illegal && bus.alu_carry_out;
                r_out_zero    <= !r_illegal && bus.alu_zf;
                r_out_illegal <= r_illegal;
`ifdef ALU_BRANCH_EVAL_EN
                r_out_taken   <= r_branch && (bus.alu_zf ^ r_br_ne);
`endif
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.alu_a         = r_alu_a;
    assign bus.alu_b         = r_alu_b;
    assign bus.alu_a_invert  = 1'b0;      // no decoded op ever inverts A
    assign bus.alu_b_invert  = r_alu_b_inv;
    assign bus.alu_carry_in  = r_alu_cin;
    assign bus.alu_operation = r_alu_op;
    assign bus.out_result    = r_out_result;
    assign bus.out_carry     = r_out_carry;
    assign bus.out_zero      = r_out_zero;
    assign bus.out_illegal   = r_out_illegal;
`ifdef ALU_BRANCH_EVAL_EN
    assign bus.out_taken     = r_out_taken;
`else
    assign bus.out_taken     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, hand sequences for backpressure/reset, random ops vs reference model.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.WIDTH(64)) tif ();

    alu_issue_ctrl #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic        carry, zero, ill, taken;
        logic [63:0] da, db;
        logic        ainv, binv, cin;
        logic [1:0]  opn;
    } obs_t;

    typedef struct {
        logic [63:0] a, b;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        obs_t        exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // environment ALU: plain combinational 64-bit ALU
    logic [63:0] m_a, m_b;
    logic [64:0] m_s;
    always_comb begin
        m_a = tif.alu_a_invert ? ~tif.alu_a : tif.alu_a;
        m_b = tif.alu_b_invert ? ~tif.alu_b : tif.alu_b;
        m_s = '0;
        case (tif.alu_operation)
            2'b00:   m_s = {1'b0, m_a & m_b};
            2'b01:   m_s = {1'b0, m_a | m_b};
            2'b10:   m_s = {1'b0, m_a} + {1'b0, m_b} + {64'd0, tif.alu_carry_in};
            default: m_s = '0;
        endcase
        tif.alu_result    = m_s[63:0];
        tif.alu_carry_out = m_s[64];
        tif.alu_zf        = (m_s[63:0] == 64'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t o, input obs_t e);
        check({tag, "_result"},  o.res,   e.res);
        check({tag, "_carry"},   o.carry, e.carry);
        check({tag, "_zero"},    o.zero,  e.zero);
        check({tag, "_illegal"}, o.ill,   e.ill);
        check({tag, "_taken"},   o.taken, e.taken);
        check({tag, "_alu_a"},   o.da,    e.da);
        check({tag, "_alu_b"},   o.db,    e.db);
        check({tag, "_drv_flags"}, {o.ainv, o.binv, o.cin, o.opn}, {e.ainv, e.binv, e.cin, e.opn});
    endtask

    // Reference model: classifies the instruction, then computes the answer arithmetically.
    function automatic obs_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] op, input logic [2:0] f3, input logic f7);
        obs_t e;
        int   kind;      // 0 add, 1 sub, 2 and, 3 or, -1 illegal
        logic is_br;
        e = '0;
        kind = -1;
        is_br = 1'b0;
        if (op == 2'd0) kind = 0;
        else if (op == 2'd1) begin
`ifdef ALU_BRANCH_EVAL_EN
            if (f3 == 3'd0 || f3 == 3'd1) begin kind = 1; is_br = 1'b1; end
`else
            kind = 1;
`endif
        end else if (op == 2'd2) begin
            if (f3 == 3'd0)             kind = f7 ? 1 : 0;
            else if (!f7 && f3 == 3'd7) kind = 2;
            else if (!f7 && f3 == 3'd6) kind = 3;
        end
        case (kind)
            0: begin e.res = a + b; e.carry = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF; e.opn = 2'd2; end
            1: begin e.res = a - b; e.carry = (a >= b); e.binv = 1'b1; e.cin = 1'b1; e.opn = 2'd2; end
            2: begin e.res = a & b; e.opn = 2'd0; end
            3: begin e.res = a | b; e.opn = 2'd1; end
            default: e.ill = 1'b1;
        endcase
        if (kind >= 0) begin
            e.zero  = (e.res == 64'd0);
            e.taken = is_br && ((a == b) != (f3 == 3'd1));
            e.da    = a;
            e.db    = b;
        end
        return e;
    endfunction

    function automatic logic drives_nonzero();
        return (|tif.alu_a) | (|tif.alu_b) | tif.alu_a_invert | tif.alu_b_invert
             | tif.alu_carry_in | (|tif.alu_operation);
    endfunction

    // Issue one op starting at a negedge in IDLE; hold out_ready low for 'hold' DONE cycles.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                          input logic [2:0] f3, input logic f7, input int hold, output obs_t o);
        o = '0;
        tif.in_a = a; tif.in_b = b; tif.alu_op = op; tif.funct3 = f3; tif.funct7_5 = f7;
        tif.in_valid = 1'b1; tif.out_ready = 1'b0;
        check("idle_in_ready", tif.in_ready, 1);
        @(posedge clk); @(negedge clk);
        // scramble inputs: the DUT must work from what it registered
        tif.in_valid = 1'b0;
        tif.in_a = {$urandom, $urandom}; tif.in_b = {$urandom, $urandom};
        tif.alu_op = 2'($urandom); tif.funct3 = 3'($urandom); tif.funct7_5 = 1'($urandom);
        check("exec_out_valid", tif.out_valid, 0);
        check("exec_in_ready", tif.in_ready, 0);
        o.da = tif.alu_a; o.db = tif.alu_b;
        o.ainv = tif.alu_a_invert; o.binv = tif.alu_b_invert; o.cin = tif.alu_carry_in; o.opn = tif.alu_operation;
        @(posedge clk); @(negedge clk);
        check("done_out_valid", tif.out_valid, 1);
        o.res = tif.out_result; o.carry = tif.out_carry; o.zero = tif.out_zero;
        o.ill = tif.out_illegal; o.taken = tif.out_taken;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); @(negedge clk);
            check("hold_out_valid", tif.out_valid, 1);
            check("hold_in_ready", tif.in_ready, 0);
            check("hold_result", tif.out_result, o.res);
            check("hold_alu_b", tif.alu_b, o.db);
        end
        tif.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tif.out_ready = 1'b0;
        check("ret_out_valid", tif.out_valid, 0);
        check("ret_in_ready", tif.in_ready, 1);
        check("ret_drv_clear", drives_nonzero(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        obs_t o, e;
        logic [63:0] ra, rb;
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic        rf7;
        logic        saw_valid;

        //            a                      b                      op     f3      f7     res                    c     z     ill   tk    da                     db                     ai    bi    ci    opn
        tbl[0]  = '{64'h1,                 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 3'b000, 1'b0, '{64'h0,                 1'b1, 1'b1, 1'b0, 1'b0, 64'h1,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b10}};
        tbl[1]  = '{64'h5,                 64'h5,                 2'b10, 3'b000, 1'b1, '{64'h0,                 1'b1, 1'b1, 1'b0, 1'b0, 64'h5,                 64'h5,                 1'b0, 1'b1, 1'b1, 2'b10}};
        tbl[2]  = '{64'hF0F0,              64'hFF00,              2'b10, 3'b111, 1'b0, '{64'hF000,              1'b0, 1'b0, 1'b0, 1'b0, 64'hF0F0,              64'hFF00,              1'b0, 1'b0, 1'b0, 2'b00}};
        tbl[3]  = '{64'hF0F0,              64'hFF00,              2'b10, 3'b110, 1'b0, '{64'hFFF0,              1'b0, 1'b0, 1'b0, 1'b0, 64'hF0F0,              64'hFF00,              1'b0, 1'b0, 1'b0, 2'b01}};
        tbl[4]  = '{64'h7,                 64'h8,                 2'b10, 3'b000, 1'b0, '{64'hF,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h7,                 64'h8,                 1'b0, 1'b0, 1'b0, 2'b10}};
        tbl[5]  = '{64'h1234,              64'h55,                2'b10, 3'b010, 1'b0, '{64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 1'b0, 2'b00}};
        tbl[6]  = '{64'h9,                 64'h9,                 2'b11, 3'b000, 1'b0, '{64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 1'b0, 2'b00}};
        tbl[7]  = '{64'hF0F0,              64'hFF00,              2'b10, 3'b111, 1'b1, '{64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 1'b0, 2'b00}};
        tbl[8]  = '{64'hA,                 64'h3,                 2'b01, 3'b000, 1'b0, '{64'h7,                 1'b1, 1'b0, 1'b0, 1'b0, 64'hA,                 64'h3,                 1'b0, 1'b1, 1'b1, 2'b10}};
        tbl[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 3'b000, 1'b0, '{64'h0,               1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2'b10}};
        tbl[10] = '{64'h3,                 64'h4,                 2'b01, 3'b000, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3,                 64'h4,                 1'b0, 1'b1, 1'b1, 2'b10}};
        tbl[11] = '{64'hF0F0,              64'hFF00,              2'b10, 3'b110, 1'b1, '{64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 1'b0, 2'b00}};

        tif.in_valid = 1'b0; tif.in_a = '0; tif.in_b = '0; tif.alu_op = 2'b00;
        tif.funct3 = 3'b000; tif.funct7_5 = 1'b0; tif.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_in_ready", tif.in_ready, 1);
        check("rst_out_valid", tif.out_valid, 0);
        check("rst_out_result", tif.out_result, 0);
        check("rst_out_flags", {tif.out_carry, tif.out_zero, tif.out_illegal, tif.out_taken}, 0);
        check("rst_drives", drives_nonzero(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", tif.in_ready, 1);

        // directed table
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].f3, tbl[i].f7, i % 3, o);
            compare_obs($sformatf("tbl%0d", i), o, tbl[i].exp);
        end

        // branch-compare handling of alu_op 01
`ifdef ALU_BRANCH_EVAL_EN
        run_op(64'h3, 64'h4, 2'b01, 3'b001, 1'b0, 0, o);
        compare_obs("bne", o, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 64'h3, 64'h4, 1'b0, 1'b1, 1'b1, 2'b10});
        run_op(64'h3, 64'h4, 2'b01, 3'b000, 1'b0, 0, o);
        compare_obs("beq", o, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3, 64'h4, 1'b0, 1'b1, 1'b1, 2'b10});
        run_op(64'h3, 64'h4, 2'b01, 3'b010, 1'b0, 0, o);
        compare_obs("br_bad", o, '{64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 2'b00});
`else
        run_op(64'h3, 64'h4, 2'b01, 3'b001, 1'b0, 0, o);
        compare_obs("sub_f1", o, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3, 64'h4, 1'b0, 1'b1, 1'b1, 2'b10});
        run_op(64'h9, 64'h9, 2'b01, 3'b010, 1'b0, 0, o);
        compare_obs("sub_f2", o, '{64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h9, 64'h9, 1'b0, 1'b1, 1'b1, 2'b10});
`endif

        // backpressure: response held 5 cycles while a second request waits
        tif.in_a = 64'hF0F0; tif.in_b = 64'hFF00; tif.alu_op = 2'b10; tif.funct3 = 3'b111; tif.funct7_5 = 1'b0;
        tif.in_valid = 1'b1; tif.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        tif.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        tif.in_a = 64'h1; tif.in_b = 64'h2; tif.alu_op = 2'b00; tif.funct3 = 3'b000;
        tif.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", tif.out_valid, 1);
            check("bp_in_ready", tif.in_ready, 0);
            check("bp_result", tif.out_result, 64'hF000);
            check("bp_alu_a", tif.alu_a, 64'hF0F0);
            @(posedge clk); @(negedge clk);
        end
        check("bp_result_end", tif.out_result, 64'hF000);
        tif.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tif.out_ready = 1'b0;
        check("bp_idle_valid", tif.out_valid, 0);
        check("bp_idle_ready", tif.in_ready, 1);
        @(posedge clk); @(negedge clk);
        tif.in_valid = 1'b0;
        check("bp_second_a", tif.alu_a, 64'h1);
        check("bp_second_b", tif.alu_b, 64'h2);
        @(posedge clk); @(negedge clk);
        check("bp_second_valid", tif.out_valid, 1);
        check("bp_second_result", tif.out_result, 64'h3);
        tif.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tif.out_ready = 1'b0;

        // reset while in EXEC discards the op
        tif.in_a = 64'h5; tif.in_b = 64'h6; tif.alu_op = 2'b00; tif.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        tif.in_valid = 1'b0;
        check("rx_exec_alu_a", tif.alu_a, 64'h5);
        rst_n = 1'b0;
        #1;
        check("rx_out_valid", tif.out_valid, 0);
        check("rx_in_ready", tif.in_ready, 1);
        check("rx_drives", drives_nonzero(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tif.out_ready = 1'b1;
        saw_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            saw_valid = saw_valid | tif.out_valid;
        end
        tif.out_ready = 1'b0;
        check("rx_no_response", saw_valid, 0);
        check("rx_in_ready_after", tif.in_ready, 1);

        // random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            rf7 = ($urandom_range(0, 3) == 0);
            e = ref_model(ra, rb, rop, rf3, rf7);
            run_op(ra, rb, rop, rf3, rf7, $urandom_range(0, 2), o);
            compare_obs($sformatf("rnd%0d", i), o, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
